// File: rtl/serial_add_ctrl_pkg.sv
// rtl/serial_add_ctrl_pkg.sv - shared types and constants for the bit-serial adder controller
package serial_add_ctrl_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Bit counter width: enough to index WIDTH bits, never narrower than one bit
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - requester-side start/done handshake and operand/result bundle
interface serial_add_ctrl_if
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );

endinterface

// File: rtl/full_from_half.sv
// rtl/full_from_half.sv - 1-bit full adder composed of two half-adder stages
module full_from_half (
    output logic sum,
    output logic carry_out,
    input  logic in1,
    input  logic in2,
    input  logic carry_in
);

    logic hs1_sum;
    logic hs1_carry;
    logic hs2_carry;

    // First half adder combines the operand bits, second folds in the carry
    assign hs1_sum   = in1 ^ in2;
    assign hs1_carry = in1 & in2;
    assign sum       = hs1_sum ^ carry_in;
    assign hs2_carry = hs1_sum & carry_in;
    assign carry_out = hs1_carry | hs2_carry;

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder: one full adder time-shared over WIDTH cycles
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_add_ctrl_if.slave  bus
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   s_sr_q, s_sr_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               fa_sum;
    logic               fa_co;

    full_from_half u_fa (
        .sum       (fa_sum),
        .carry_out (fa_co),
        .in1       (a_sr_q[0]),
        .in2       (b_sr_q[0]),
        .carry_in  (carry_q)
    );

    // State and datapath registers; reset discards any in-flight addition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            s_sr_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            s_sr_q  <= s_sr_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath sequencing: load, shift one bit per cycle, publish on the last bit
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        s_sr_d  = s_sr_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_sr_d  = bus.a;
                    b_sr_d  = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                // New sum bit enters at the MSB; the oldest bit falls off the bottom
                s_sr_d  = WIDTH'({fa_sum, s_sr_q} >> 1);
                carry_d = fa_co;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // Counter holds here so it never wraps within an operation
                    sum_d   = s_sr_d;
                    cout_d  = fa_co;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - randomized self-checking bench for serial_add_ctrl against an arithmetic model
module tb_serial_add_ctrl;
    import serial_add_ctrl_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [W:0] last_res = '0;

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input string tag);
        logic [W:0] want;
        int k;
        bit got;
        want = model(a, b, c);
        got = 0;
        bus.a = a;
        bus.b = b;
        bus.cin = c;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_vec++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL %s accept: busy=%b done=%b want busy=1 done=0", tag, bus.busy, bus.done);
        end
        for (k = 1; k <= W + 4; k++) begin
            tick();
            if (bus.done === 1'b1) begin
                got = 1;
                break;
            end
            n_vec++;
            if ({bus.cout, bus.sum} !== last_res || bus.busy !== 1'b1) begin
                n_err++;
                $display("FAIL %s run_hold cyc%0d: res=%h busy=%b want res=%h busy=1",
                         tag, k, {bus.cout, bus.sum}, bus.busy, last_res);
            end
        end
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL %s timeout: no done within %0d cycles", tag, W + 4);
        end else begin
            if (k != W || {bus.cout, bus.sum} !== want || bus.busy !== 1'b0) begin
                n_err++;
                $display("FAIL %s result: lat=%0d res=%h busy=%b want lat=%0d res=%h busy=0",
                         tag, k, {bus.cout, bus.sum}, bus.busy, W, want);
            end
            last_res = want;
            tick();
            n_vec++;
            if (bus.done !== 1'b0 || {bus.cout, bus.sum} !== want) begin
                n_err++;
                $display("FAIL %s done_pulse: done=%b res=%h want done=0 res=%h", tag, bus.done, {bus.cout, bus.sum}, want);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        tick();
        tick();
        n_vec++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== '0 || bus.cout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b want all 0", bus.busy, bus.done, bus.sum, bus.cout);
        end
        rst_n = 1'b1;
        last_res = '0;
        tick();
    endtask

    task automatic test_directed();
        run_op(8'h5A, 8'h3C, 1'b0, "dir_5a_3c");
        run_op(8'hFF, 8'h01, 1'b0, "dir_ripple");
        run_op(8'hFF, 8'hFF, 1'b1, "dir_max");
        run_op(8'h00, 8'h00, 1'b1, "dir_cin_only");
    endtask

    task automatic test_start_ignored();
        logic [W:0] want;
        int ndone;
        want = model(8'h23, 8'h47, 1'b1);
        ndone = 0;
        bus.a = 8'h23;
        bus.b = 8'h47;
        bus.cin = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        bus.a = 8'h11;
        bus.b = 8'h11;
        bus.cin = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) begin
                ndone++;
                n_vec++;
                if ({bus.cout, bus.sum} !== want) begin
                    n_err++;
                    $display("FAIL ignore_start result: res=%h want %h", {bus.cout, bus.sum}, want);
                end
            end
            tick();
        end
        n_vec++;
        if (ndone != 1) begin
            n_err++;
            $display("FAIL ignore_start done_count: got %0d want 1", ndone);
        end
        last_res = want;
    endtask

    task automatic test_reset_mid_run();
        int ndone;
        ndone = 0;
        bus.a = 8'hC3;
        bus.b = 8'h5F;
        bus.cin = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== '0 || bus.cout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid immediate: busy=%b done=%b sum=%h cout=%b want all 0", bus.busy, bus.done, bus.sum, bus.cout);
        end
        tick();
        rst_n = 1'b1;
        last_res = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
        end
        n_vec++;
        if (ndone != 0) begin
            n_err++;
            $display("FAIL reset_mid no_done: active cycles %0d want 0", ndone);
        end
        run_op(8'hA7, 8'h6E, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [W:0] exp_q[$];
        logic [W:0] want;
        logic [W-1:0] cur_a, cur_b;
        logic cur_c;
        logic prev_busy;
        int cyc, last_done, ndone;
        cur_a = W'($urandom);
        cur_b = W'($urandom);
        cur_c = 1'($urandom);
        bus.a = cur_a;
        bus.b = cur_b;
        bus.cin = cur_c;
        bus.start = 1'b1;
        prev_busy = bus.busy;
        last_done = -1;
        ndone = 0;
        for (cyc = 0; cyc < 100 && ndone < 6; cyc++) begin
            tick();
            if (bus.busy === 1'b1 && prev_busy !== 1'b1) begin
                exp_q.push_back(model(cur_a, cur_b, cur_c));
                cur_a = W'($urandom);
                cur_b = W'($urandom);
                cur_c = 1'($urandom);
                bus.a = cur_a;
                bus.b = cur_b;
                bus.cin = cur_c;
            end
            if (bus.done === 1'b1) begin
                ndone++;
                want = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                n_vec++;
                if ({bus.cout, bus.sum} !== want) begin
                    n_err++;
                    $display("FAIL b2b result %0d: res=%h want %h", ndone, {bus.cout, bus.sum}, want);
                end
                if (last_done >= 0) begin
                    n_vec++;
                    if (cyc - last_done != W + 2) begin
                        n_err++;
                        $display("FAIL b2b spacing %0d: got %0d want %0d", ndone, cyc - last_done, W + 2);
                    end
                end
                last_done = cyc;
                last_res = want;
                if (ndone == 6) bus.start = 1'b0;
            end
            prev_busy = bus.busy;
        end
        bus.start = 1'b0;
        tick();
        n_vec++;
        if (ndone != 6 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL b2b count: dones=%0d pending=%0d want 6 and 0", ndone, exp_q.size());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
